// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: default widths,
// occupancy encoding and the bundle layout of each stage boundary.
package pipe_pkg;

  // IF/ID boundary
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_data_t;

  // ID/EX boundary
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } id_ex_ctrl_t;

  // EX/MEM boundary
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_data_t;

  // MEM/WB boundary
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mem_wb_ctrl_t;

  // Default widths follow the EX/MEM bundle (4 and 101 bits)
  localparam int unsigned PIPE_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int unsigned PIPE_DATA_W = $bits(ex_mem_data_t);
  localparam int unsigned OCC_W       = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_TWO   = 2'd2;

  // S is only ever valid while M is valid, so S alone implies two beats
  function automatic logic [OCC_W-1:0] occ_enc(input logic m_valid, input logic s_valid);
    if (s_valid) return OCC_TWO;
    if (m_valid) return OCC_ONE;
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One holding slot of a pipeline stage: valid bit plus ctrl/data registers.
// Priority: rst, then load, then clear. Clear drops only the valid bit.
import pipe_pkg::*;

module pipe_slot #(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Slot register update
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and
// back-pressure. Optional skid slot enabled by defining PIPE_STAGE_SKID_EN,
// which makes in_ready a flop output. out_ctrl is masked to zero whenever no
// valid beat is held so a bubble can never write state downstream.
import pipe_pkg::*;

module pipe_stage_reg #(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  logic              accept;
  logic              emit;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              m_load;
  logic              m_clear;
  logic [CTRL_W-1:0] m_ld_ctrl;
  logic [DATA_W-1:0] m_ld_data;

  assign accept = in_valid && in_ready;
  assign emit   = m_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              s_load;
  logic              s_clear;
  logic              m_valid_nxt;
  logic              s_valid_nxt;
  logic [OCC_W-1:0]  occ_q;

  // Ready only depends on the skid flop, never on out_ready
  assign in_ready = !s_valid;

  // Slot steering: refill M from S first, else fill M, else spill into S
  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    m_ld_ctrl = in_ctrl;
    m_ld_data = in_data;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (emit && s_valid) begin
      m_load    = 1'b1;
      m_ld_ctrl = s_ctrl;
      m_ld_data = s_data;
      s_clear   = 1'b1;
    end else if (accept && (!m_valid || emit)) begin
      m_load = 1'b1;
    end else if (accept) begin
      s_load = 1'b1;
    end else if (emit) begin
      m_clear = 1'b1;
    end
    m_valid_nxt = m_load || (m_valid && !m_clear);
    s_valid_nxt = s_load || (s_valid && !s_clear);
  end

  // Occupancy tracked in its own register so the output is a pure flop
  always_ff @(posedge clk) begin
    if (rst) occ_q <= OCC_EMPTY;
    else     occ_q <= occ_enc(m_valid_nxt, s_valid_nxt);
  end

  assign occupancy = occ_q;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (s_load),
    .clear   (s_clear),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (s_valid),
    .ctrl    (s_ctrl),
    .data    (s_data)
  );
`else
  // Single slot: ready passes straight through from downstream
  assign in_ready = !m_valid || out_ready;

  // Slot steering: load on accept, drop after an emit with no refill
  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    m_ld_ctrl = in_ctrl;
    m_ld_data = in_data;
    if (flush)       m_clear = 1'b1;
    else if (accept) m_load  = 1'b1;
    else if (emit)   m_clear = 1'b1;
  end

  assign occupancy = occ_enc(m_valid, 1'b0);
`endif

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .clear   (m_clear),
    .ld_ctrl (m_ld_ctrl),
    .ld_data (m_ld_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         mq[$];
  logic [DW-1:0] m_last;
  logic [DW-1:0] emitted[$];
  bit            chk_en = 1'b0;
  bit            m_acc;
  bit            m_em;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model readiness: room in the held-beat queue (plus pass-through without skid)
  function automatic bit m_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (out_ready === 1'b1);
`endif
  endfunction

  // Reference model: FIFO of held beats; head is what the output shows
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_last = '0;
      chk_en = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_acc = in_valid && m_ready();
      m_em  = (mq.size() > 0) && out_ready;
      if (m_em) void'(mq.pop_front());
      if (m_acc) mq.push_back({in_ctrl, in_data});
    end
    if (mq.size() > 0) m_last = mq[0].d;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    beat_t hd;
    if (chk_en) begin
      hd = (mq.size() > 0) ? mq[0] : '0;
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("out_ctrl", 32'(out_ctrl), 32'(hd.c));
      chk("out_data", 32'(out_data), 32'(m_last));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      if (out_valid && out_ready) emitted.push_back(out_data);
    end
  end

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl, output bit acc);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = iv && in_ready && !rst && !fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    emitted.delete();
  endtask

  bit acc;
  int nxt;
  int c;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h00AB;
    in_ctrl = 4'hF; out_ready = 1'b1;

    // Reset held two cycles with a beat offered
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_model_empty", 32'(mq.size()), 32'd0);

    // Streaming 1..8 back-to-back
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, acc);
      chk("stream_acc", 32'(acc), 32'd1);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", 32'(out_data), 32'(i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, acc);
    drive(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("stream_count", 32'(emitted.size()), 32'd8);
    for (int i = 0; i < emitted.size(); i++) chk("stream_order", 32'(emitted[i]), 32'(i + 1));

`ifdef PIPE_STAGE_SKID_EN
    // Stall three cycles while beat 2 is at the output
    do_reset();
    nxt = 1;
    c = 0;
    while (emitted.size() < 6 && c < 40) begin
      drive(nxt <= 6, DW'(nxt), 4'h1, !(c >= 2 && c <= 4), 1'b0, acc);
      if (acc) nxt++;
      if (c == 2) begin
        chk("stall_occ2", 32'(occupancy), 32'd2);
        chk("stall_head", 32'(out_data), 32'd2);
      end
      if (c >= 2 && c <= 4) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (c == 3 || c == 4) chk("stall_no_acc", 32'(acc), 32'd0);
      c++;
    end
    chk("stall_count", 32'(emitted.size()), 32'd6);
    for (int i = 0; i < emitted.size(); i++) chk("stall_order", 32'(emitted[i]), 32'(i + 1));
`endif

    // Flush with the stage full and a beat offered
    do_reset();
    drive(1'b1, 16'h0011, 4'h3, 1'b0, 1'b0, acc);
    drive(1'b1, 16'h0022, 4'h5, 1'b0, 1'b0, acc);
    chk("flush_pre_occ", 32'(occupancy), 32'(CAP));
    drive(1'b1, 16'h0055, 4'h7, 1'b0, 1'b1, acc);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ctrl", 32'(out_ctrl), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_data_hold", 32'(out_data), 32'h11);
    drive(1'b0, '0, '0, 1'b1, 1'b0, acc);
    drive(1'b1, 16'h0066, 4'h2, 1'b1, 1'b0, acc);
    chk("flush_next_valid", 32'(out_valid), 32'd1);
    chk("flush_next_data", 32'(out_data), 32'h66);
    drive(1'b0, '0, '0, 1'b1, 1'b0, acc);
    drive(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("flush_emit_count", 32'(emitted.size()), 32'd1);
    if (emitted.size() > 0) chk("flush_emit_data", 32'(emitted[0]), 32'h66);

    // Bubble masking: ctrl visible for exactly one cycle
    do_reset();
    drive(1'b1, 16'h0077, 4'hF, 1'b1, 1'b0, acc);
    chk("bubble_ctrl_on", 32'(out_ctrl), 32'hF);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h1234, 4'hF, 1'b1, 1'b0, acc);
      chk("bubble_ctrl_off", 32'(out_ctrl), 32'd0);
      chk("bubble_valid", 32'(out_valid), 32'd0);
      chk("bubble_data_hold", 32'(out_data), 32'h77);
    end

    // Random stress against the model
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      drive($urandom_range(0, 9) < 7, DW'($urandom), CW'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, acc);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor of the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined processor. It carries an opaque control bundle and data bundle across one stage boundary using a valid/ready handshake, with flush (bubble insertion) and back-pressure. A compile-time option adds a skid slot so that `in_ready` is registered. Control bits are forced to zero whenever the stage holds no valid beat, so a bubble can never write the register file or memory.

## Interface
- `DATA_W`, default 101: data bundle width (ALU result, write data, PC+4 and rd for the EX/MEM use).
- `CTRL_W`, default 4: control bundle width (RegWrite, MemWrite and ResultSrc[1:0] for the EX/MEM use).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  synchronous kill of all held beats and of the beat offered this cycle.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream data bundle.
- `out_valid`  out  1  beat present downstream.
- `out_ready`  in  1  downstream accepts (0 = stall).
- `out_ctrl`  out  CTRL_W  control bundle; all-zero when `out_valid`=0.
- `out_data`  out  DATA_W  data bundle; holds its last value when `out_valid`=0.
- `occupancy`  out  2  number of held beats (0..2; 0..1 without skid).

## Operation
- Accept = `in_valid && in_ready`. Emit = `out_valid && out_ready`.
- Main slot M drives the outputs. Skid slot S exists only with skid enabled.
- Beats leave in strict arrival order. No beat is duplicated or lost except by `flush`.
- Priority each cycle, highest first: `rst`, then `flush`, then normal operation.
- Reset:
  - M and S become invalid.
  - M and S control and data registers become 0.
  - Outputs after reset: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=1 in the first cycle after reset.
- Flush:
  - Next cycle M and S are invalid; the beat offered in the flush cycle is dropped.
  - Data registers are left unchanged; `out_ctrl` reads 0 because M is invalid.
- Normal operation with skid:
  - M empty or emitting, S empty: an accepted beat loads M.
  - M full and not emitting: an accepted beat loads S.
  - M emitting and S full: M loads from S and S empties. No accept is possible because `in_ready`=0.
- Normal operation without skid: an accepted beat loads M. `in_ready = !M_valid || out_ready`, so the path is combinational from `out_ready`.
- `out_ctrl = M_valid ? M_ctrl : 0`. This AND-mask is the only combinational logic on the outputs.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 beat/cycle while `out_ready`=1, with or without skid.
- With skid:
  - `in_ready = !S_valid`, a pure flop output with no combinational path from `out_ready`.
  - After `out_ready` falls with M full, exactly one more beat is absorbed into S; `in_ready` drops the following cycle.
  - After `out_ready` rises with S full: the S beat moves into M at the next edge, and `in_ready` rises in the cycle after that edge.
- `flush` together with `out_ready`=1 in the same cycle: downstream still sees that cycle's emit, since it is combinationally visible. The state is cleared afterwards.
- `rst` asserted mid-stream discards all beats, and `in_ready` deasserts for no cycle beyond the reset cycle itself.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - S slot instantiated.
  - `in_ready` registered.
  - `occupancy` ranges 0..2.
- Not defined:
  - No S slot.
  - `in_ready` combinational from `out_ready`.
  - `occupancy[1]` tied to 0.
  - Area is one register of width CTRL_W+DATA_W+1.

## Structure
- Shared package `pipe_pkg`:
  - Default widths `PIPE_CTRL_W`=4 and `PIPE_DATA_W`=101.
  - Occupancy encoding constants `OCC_EMPTY`, `OCC_ONE`, `OCC_TWO`.
  - Packed struct typedefs for the bundle of each stage boundary (e.g. `ex_mem_ctrl_t`).
- One natural sub-module, `pipe_slot`: a valid bit plus ctrl/data register with load, clear and sync-reset inputs. It is instantiated once for M and, under the macro, once for S.

## Test plan
- Reset behaviour: hold `rst`=1 for 2 cycles while `in_valid`=1 with `in_data`=0xAB. Required: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1 after release.
- Streaming: send data 1..8 back-to-back with `out_ready`=1. Required: outputs 1..8 in order, each one cycle after its accept, no gaps.
- Stall (skid enabled): stream data 1..6 and drop `out_ready` for 3 cycles while beat 2 is at the output. Required:
  - Beat 3 is captured in S and `occupancy` reaches 2.
  - `in_ready`=0 for the stall.
  - Output order after resume is 1..6 with none lost.
- Flush: flush while `occupancy`=2 and `in_valid`=1 carrying data 0x55. Required:
  - Next cycle `out_valid`=0 and `out_ctrl`=0.
  - 0x55 never appears on the output.
  - The next beat after the flush emits normally.
- Bubble masking: send `in_ctrl`=0xF followed by idle cycles. Required: `out_ctrl`=0xF for exactly one cycle, then 0 while `out_data` keeps its value.
- Random stress (both macro settings): 10k cycles of random `in_valid`, `out_ready` and sparse `flush`. Required: a scoreboard matches order and content, and `occupancy` equals the count of beats accepted but not yet emitted.
